// File: rtl/prog_loader.sv
// prog_loader: UART-fed program loader for an instruction memory.
//
// Receives a little-endian length header of LEN_BYTES bytes giving the word
// count N, then N little-endian DATA_W-bit words, and writes each completed
// word into instruction memory while holding the CPU in reset. An idle gap
// of TIMEOUT_CYC cycles between bytes aborts the load.
//
// Parameters:
//   DATA_W       instruction word width (multiple of 8, 8..64)
//   ADDR_W       instruction memory word-address width
//   LEN_BYTES    byte count of the length header
//   TIMEOUT_CYC  maximum idle gap in cycles between bytes
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start         one-cycle request to begin a load
//   rx_valid      one-cycle strobe qualifying rx_data
//   rx_data       received byte
//   fetch_pc      CPU byte program counter (drives imem_addr when not loading)
//   imem_addr     instruction memory word address
//   imem_we       instruction memory write enable
//   imem_wdata    instruction memory write data
//   cpu_hold      CPU held in reset while a load is in progress
//   done          last load completed successfully
//   err           last load aborted
//   words_loaded  words written in the current or last load
module prog_loader #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 14,
  parameter int LEN_BYTES   = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W+1:0] fetch_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int BPW   = DATA_W / 8;
  localparam int LEN_W = 8 * LEN_BYTES;
  localparam int CNT_W = 8;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  // Wide enough to compare the header value against 2^ADDR_W without overflow.
  localparam int CMP_W = ((LEN_W > ADDR_W + 1) ? LEN_W : ADDR_W + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  byte_cnt;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  len_nx;
  logic [DATA_W-1:0] word_buf;
  logic [DATA_W-1:0] word_nx;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [ADDR_W:0]   wcnt;
  logic              vld_p1;
  logic [DATA_W-1:0] wdata_p1;

  logic loading;
  logic accept;
  logic hdr_last;
  logic word_last;
  logic tmo_hit;
  logic last_write;
  logic restart;
  logic len_zero;
  logic len_big;
  logic pc_lo_unused;

  // Byte-offset bits of the CPU PC are irrelevant for word addressing.
  assign pc_lo_unused = ^fetch_pc[1:0];

  assign loading    = (state == S_LEN) || (state == S_DATA);
  assign accept     = rx_valid && loading;
  assign restart    = start && !loading;
  assign hdr_last   = accept && (state == S_LEN) &&
                      (byte_cnt == CNT_W'(LEN_BYTES - 1));
  assign tmo_hit    = loading && !accept &&
                      (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  // The edge ending the write of word N-1 finishes the load.
  assign last_write = vld_p1 &&
                      ((CMP_W'(wcnt) + CMP_W'(1)) == CMP_W'(len_reg));
  // A byte landing on the final write cycle is dropped, so no extra word
  // can be started once the load is complete.
  assign word_last  = accept && (state == S_DATA) && !last_write &&
                      (byte_cnt == CNT_W'(BPW - 1));
  assign len_zero   = (len_nx == '0);
  assign len_big    = CMP_W'(len_nx) > (CMP_W'(1) << ADDR_W);

  // Little-endian byte insertion at the current byte position.
  always_comb begin
    len_nx  = len_reg;
    word_nx = word_buf;
    for (int i = 0; i < LEN_BYTES; i++) begin
      if (byte_cnt == CNT_W'(i)) len_nx[8*i +: 8] = rx_data;
    end
    for (int i = 0; i < BPW; i++) begin
      if (byte_cnt == CNT_W'(i)) word_nx[8*i +: 8] = rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nx = S_LEN;
      end
      S_LEN: begin
        if (hdr_last) begin
          if (len_zero)     state_nx = S_DONE;
          else if (len_big) state_nx = S_ERR;
          else              state_nx = S_DATA;
        end else if (tmo_hit) begin
          state_nx = S_ERR;
        end
      end
      S_DATA: begin
        if (last_write)   state_nx = S_DONE;
        else if (tmo_hit) state_nx = S_ERR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_hold = loading;
    done     = (state == S_DONE);
    err      = (state == S_ERR);
    // rst gates the pending write combinationally so an abort issues nothing.
    imem_we  = vld_p1 && loading && !rst;
    if (loading) imem_addr = wcnt[ADDR_W-1:0];
    else         imem_addr = fetch_pc[ADDR_W+1:2];
  end

  assign imem_wdata   = wdata_p1;
  assign words_loaded = wcnt;

  // Stage p0: byte capture, header/word assembly, timeout.
  // Stage p1: completed word presented to memory for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      len_reg  <= '0;
      word_buf <= '0;
      tmo_cnt  <= '0;
      wcnt     <= '0;
      vld_p1   <= 1'b0;
      wdata_p1 <= '0;
    end else if (restart) begin
      byte_cnt <= '0;
      len_reg  <= '0;
      word_buf <= '0;
      tmo_cnt  <= '0;
      wcnt     <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= word_last;
      if (word_last) wdata_p1 <= word_nx;
      if (vld_p1)    wcnt     <= wcnt + 1'b1;

      if (accept)       tmo_cnt <= '0;
      else if (loading) tmo_cnt <= tmo_cnt + 1'b1;

      if (accept && (state == S_LEN)) begin
        len_reg  <= len_nx;
        byte_cnt <= hdr_last ? '0 : byte_cnt + 1'b1;
      end
      if (accept && (state == S_DATA) && !last_write) begin
        word_buf <= word_nx;
        byte_cnt <= word_last ? '0 : byte_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader (DATA_W=32, ADDR_W=14, LEN_BYTES=4,
// TIMEOUT_CYC=100). Writes seen on the memory port are logged on the falling
// edge and compared against hand-computed addresses and words.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [15:0] fetch_pc;
  logic [13:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [14:0] words_loaded;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [13:0] wa[$];
  logic [31:0] wd[$];

  prog_loader #(
    .DATA_W(32), .ADDR_W(14), .LEN_BYTES(4), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .fetch_pc(fetch_pc), .imem_addr(imem_addr),
    .imem_we(imem_we), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_cnt++;
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [7:0] seq1 [12];
  logic [7:0] seq5 [5];
  logic [7:0] seq6 [4];
  int base;

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    fetch_pc = 16'h0000;
    seq1 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00};
    seq5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    seq6 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_we", imem_we, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_words", words_loaded, 0);

    // rx_valid in the start cycle is ignored; then a zero-length header
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'h05;
    tick();
    start = 1'b0; rx_valid = 1'b0;
    check("start_hold", cpu_hold, 1);
    send(8'h00); send(8'h00); send(8'h00);
    check("hdr3_still_len", cpu_hold, 1);
    check("hdr3_not_done", done, 0);
    send(8'h00);
    check("zero_done", done, 1);
    check("zero_hold", cpu_hold, 0);
    check("zero_nowrite", wr_cnt, 0);

    // Two-word program, back-to-back bytes
    base = wr_cnt;
    do_start();
    for (int i = 0; i < 12; i++) begin
      rx_valid = 1'b1;
      rx_data  = seq1[i];
      tick();
      if (i == 7) begin
        check("w0_we", imem_we, 1);
        check("w0_addr", imem_addr, 0);
        check("w0_data", imem_wdata, 32'h00000013);
      end
    end
    rx_valid = 1'b0;
    check("w1_we", imem_we, 1);
    check("w1_addr", imem_addr, 1);
    check("w1_data", imem_wdata, 32'h00100093);
    tick();
    check("p2_done", done, 1);
    check("p2_err", err, 0);
    check("p2_words", words_loaded, 2);
    check("p2_hold", cpu_hold, 0);
    check("p2_we_off", imem_we, 0);
    check("p2_wrcnt", wr_cnt - base, 2);
    if (wr_cnt - base == 2) begin
      check("p2_log_a0", wa[base], 0);
      check("p2_log_d0", wd[base], 32'h00000013);
      check("p2_log_a1", wa[base+1], 1);
      check("p2_log_d1", wd[base+1], 32'h00100093);
    end

    // CPU fetch address passes through when not loading
    fetch_pc = 16'h000C;
    #1;
    check("fetch_addr", imem_addr, 3);
    do_start();
    check("restart_hold", cpu_hold, 1);
    check("restart_words", words_loaded, 0);
    check("restart_done", done, 0);

    // Oversized header (N = 16385)
    base = wr_cnt;
    send(8'h01); send(8'h40); send(8'h00); send(8'h00);
    check("big_err", err, 1);
    check("big_done", done, 0);
    check("big_hold", cpu_hold, 0);
    check("big_nowrite", wr_cnt - base, 0);

    // N = 16384 is the largest legal size: must enter DATA
    do_start();
    send(8'h00); send(8'h40); send(8'h00); send(8'h00);
    check("max_hold", cpu_hold, 1);
    check("max_err", err, 0);
    // rst wins over start and rx_valid in the same cycle
    rst = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
    tick();
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0;
    check("rstprio_hold", cpu_hold, 0);
    check("rstprio_err", err, 0);
    check("rstprio_done", done, 0);

    // Timeout: N=3, five bytes, then silence
    base = wr_cnt;
    do_start();
    send(8'h03); send(8'h00); send(8'h00); send(8'h00);
    for (int i = 0; i < 5; i++) send(seq5[i]);
    check("tmo_words", words_loaded, 1);
    for (int i = 0; i < 99; i++) tick();
    check("tmo_99_err", err, 0);
    check("tmo_99_hold", cpu_hold, 1);
    tick();
    check("tmo_100_err", err, 1);
    check("tmo_100_hold", cpu_hold, 0);
    check("tmo_words_end", words_loaded, 1);
    check("tmo_wrcnt", wr_cnt - base, 1);
    if (wr_cnt - base == 1) begin
      check("tmo_log_a", wa[base], 0);
      check("tmo_log_d", wd[base], 32'h44332211);
    end

    // rst during the write cycle of the first word
    base = wr_cnt;
    fetch_pc = 16'h0000;
    do_start();
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    for (int i = 0; i < 4; i++) send(seq6[i]);
    rst = 1'b1;
    #1;
    check("abort_we_gated", imem_we, 0);
    tick();
    rst = 1'b0;
    check("abort_hold", cpu_hold, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    check("abort_we", imem_we, 0);
    check("abort_wdata", imem_wdata, 0);
    check("abort_words", words_loaded, 0);
    check("abort_addr", imem_addr, 0);
    tick();
    check("abort_nowrite", wr_cnt - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
